// File: rtl/md_seq_ctrl.sv
// Sequencing controller for the shared iterative multiply/divide unit: one
// MUL/DIV/REM request at a time, radix-2 loop, valid/ready result, flushable.
module md_seq_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic            req_in_1_signed,
    input  logic            req_in_2_signed,
    input  logic [1:0]      req_out_sel,
    input  logic [XLEN-1:0] req_in_1,
    input  logic [XLEN-1:0] req_in_2,
    input  logic            kill,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_COMPUTE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [1:0] MD_OP_DIV  = 2'd1;
    localparam logic [1:0] MD_OP_REM  = 2'd2;
    localparam logic [1:0] MD_OUT_HI  = 2'd1;

    state_t              r_state;
    logic                r_req_ready;
    logic                r_resp_valid;
    logic [XLEN-1:0]     r_resp_result;
    logic                r_busy;
    logic [CNT_W-1:0]    r_cnt;

    logic [1:0]          r_op;
    logic                r_s1;
    logic                r_s2;
    logic [1:0]          r_out_sel;
    logic [XLEN-1:0]     r_in_1;
    logic [XLEN-1:0]     r_in_2;
    logic [XLEN-1:0]     r_a;        // multiplicand, or dividend bits still to shift in
    logic [XLEN-1:0]     r_b;        // multiplier bits still to consume, or divisor
    logic [2*XLEN-1:0]   r_acc;      // product, or {remainder, quotient}
    logic                r_neg_pq;   // product / quotient sign (same rule for MUL and DIV)
    logic                r_neg_r;
    logic                r_div_zero;

    logic                w_is_div;
    logic                w_is_rem;
    logic                w_is_mul;
    logic                w_is_hi;
    logic                w_neg1;
    logic                w_neg2;
    logic [XLEN-1:0]     w_mag1;
    logic [XLEN-1:0]     w_mag2;
    logic [XLEN:0]       w_add;
    logic [2*XLEN-1:0]   w_mul_acc;
    logic [XLEN:0]       w_rem_sh;
    logic                w_ge;
    logic [XLEN-1:0]     w_rem_diff;
    logic [XLEN-1:0]     w_rem_new;
    logic [2*XLEN-1:0]   w_div_acc;
    logic [2*XLEN-1:0]   w_acc_next;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quot;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_result;

    assign w_is_div = (r_op == MD_OP_DIV);
    assign w_is_rem = (r_op == MD_OP_REM);
    assign w_is_mul = !w_is_div && !w_is_rem;
    // An illegal op (3) falls into MUL and always returns the low half.
    assign w_is_hi  = (r_op == 2'd0) && (r_out_sel == MD_OUT_HI);

    assign w_neg1 = r_s1 & r_in_1[XLEN-1];
    assign w_neg2 = r_s2 & r_in_2[XLEN-1];
    assign w_mag1 = w_neg1 ? -r_in_1 : r_in_1;
    assign w_mag2 = w_neg2 ? -r_in_2 : r_in_2;

    // Shift-add step: add into the upper half with carry, then shift right.
    assign w_add     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_b[0] ? {1'b0, r_a} : '0);
    assign w_mul_acc = {w_add, r_acc[XLEN-1:1]};

    // Restoring step: the shifted remainder needs one extra bit before the compare.
    assign w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_a[XLEN-1]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_b});
    assign w_rem_diff = w_rem_sh[XLEN-1:0] - r_b;
    assign w_rem_new  = w_ge ? w_rem_diff : w_rem_sh[XLEN-1:0];
    assign w_div_acc  = {w_rem_new, r_acc[XLEN-2:0], w_ge};

    assign w_acc_next = w_is_mul ? w_mul_acc : w_div_acc;
    assign w_prod     = r_neg_pq ? -w_acc_next : w_acc_next;
    assign w_quot     = w_acc_next[XLEN-1:0];
    assign w_rem      = w_acc_next[2*XLEN-1:XLEN];

    // The result is formed from the final iteration's output so it can be
    // registered on the same edge that enters DONE.
    always_comb begin
        w_result = w_prod[XLEN-1:0];
        if (w_is_div) begin
            w_result = r_div_zero ? '1 : (r_neg_pq ? -w_quot : w_quot);
        end else if (w_is_rem) begin
            w_result = r_div_zero ? r_in_1 : (r_neg_r ? -w_rem : w_rem);
        end else if (w_is_hi) begin
            w_result = w_prod[2*XLEN-1:XLEN];
        end
    end

    // NOTE: only control state is reset; the datapath registers are always
    // loaded in SETUP before they are read, so they carry no reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_req_ready   <= 1'b1;
            r_resp_valid  <= 1'b0;
            r_resp_result <= '0;
            r_busy        <= 1'b0;
            r_cnt         <= '0;
        end else if (kill && (r_state != S_IDLE)) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && !kill) begin
                        r_op        <= req_op;
                        r_s1        <= req_in_1_signed;
                        r_s2        <= req_in_2_signed;
                        r_out_sel   <= req_out_sel;
                        r_in_1      <= req_in_1;
                        r_in_2      <= req_in_2;
                        r_state     <= S_SETUP;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                S_SETUP: begin
                    r_a        <= w_mag1;
                    r_b        <= w_mag2;
                    r_neg_pq   <= w_neg1 ^ w_neg2;
                    r_neg_r    <= w_neg1;
                    r_div_zero <= (r_in_2 == '0);
                    r_acc      <= '0;
                    r_cnt      <= CNT_W'(XLEN - 1);
                    r_state    <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    r_acc <= w_acc_next;
                    if (w_is_mul) begin
                        r_b <= r_b >> 1;
                    end else begin
                        r_a <= r_a << 1;
                    end
                    if (r_cnt == '0) begin
                        r_state       <= S_DONE;
                        r_resp_valid  <= 1'b1;
                        r_resp_result <= w_result;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_result = r_resp_result;
    assign busy        = r_busy;

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Directed bench for md_seq_ctrl: hand-computed MUL/DIV/REM results, latency,
// result hold, kill and reset behaviour.
module tb_md_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic        req_in_1_signed;
    logic        req_in_2_signed;
    logic [1:0]  req_out_sel;
    logic [31:0] req_in_1;
    logic [31:0] req_in_2;
    logic        kill;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    md_seq_ctrl #(.XLEN(32), .CNT_W(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_in_1_signed (req_in_1_signed),
        .req_in_2_signed (req_in_2_signed),
        .req_out_sel     (req_out_sel),
        .req_in_1        (req_in_1),
        .req_in_2        (req_in_2),
        .kill            (kill),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_result     (resp_result),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Present a request for one cycle; returns in the SETUP cycle (cycle 1).
    task automatic send(input logic [1:0] op, input logic s1, input logic s2,
                        input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_op          = op;
        req_in_1_signed = s1;
        req_in_2_signed = s2;
        req_out_sel     = sel;
        req_in_1        = a;
        req_in_2        = b;
        req_valid       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Counts the cycle in which resp_valid is first seen, relative to acceptance.
    task automatic wait_resp(output int cyc);
        cyc = 1;
        while (!resp_valid && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic take();
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic s1, input logic s2,
                          input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int hold);
        int cyc;
        send(op, s1, s2, sel, a, b);
        wait_resp(cyc);
        check({tag, " latency"}, 64'(cyc), 64'd34);
        check({tag, " result"}, {32'd0, resp_result}, {32'd0, exp});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold"}, {31'd0, resp_valid, resp_result}, {31'd0, 1'b1, exp});
        end
        take();
        check({tag, " back idle"}, {62'd0, resp_valid, req_ready}, 64'b01);
    endtask

    initial begin
        int  cyc;
        bit  saw_valid;
        reset           = 1'b1;
        req_valid       = 1'b0;
        req_op          = 2'd0;
        req_in_1_signed = 1'b0;
        req_in_2_signed = 1'b0;
        req_out_sel     = 2'd0;
        req_in_1        = '0;
        req_in_2        = '0;
        kill            = 1'b0;
        resp_ready      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset state", {29'd0, req_ready, resp_valid, busy, resp_result}, {29'd0, 3'b100, 32'd0});
        reset = 1'b0;

        // MUL family
        run_op("mul 7*6",      2'd0, 1'b0, 1'b0, 2'd0, 32'd7,        32'd6,        32'h0000002A, 5);
        run_op("mulh -1*-1",   2'd0, 1'b1, 1'b1, 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0);
        run_op("mulhu",        2'd0, 1'b0, 1'b0, 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
        run_op("mulhsu -1*2",  2'd0, 1'b1, 1'b0, 2'd1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 0);
        run_op("mul sel3 lo",  2'd0, 1'b0, 1'b0, 2'd3, 32'h00010000, 32'h00010003, 32'h00030000, 0);
        run_op("op3 as mullo", 2'd3, 1'b0, 1'b0, 2'd1, 32'h00010000, 32'h00010000, 32'h00000000, 0);

        // DIV / REM family
        run_op("div -7/2",     2'd1, 1'b1, 1'b1, 2'd0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0);
        run_op("rem -7%2",     2'd2, 1'b1, 1'b1, 2'd0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0);
        run_op("divu",         2'd1, 1'b0, 1'b0, 2'd0, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 0);
        run_op("remu 100%7",   2'd2, 1'b0, 1'b0, 2'd0, 32'd100,      32'd7,        32'd2,        0);
        run_op("div 5/0",      2'd1, 1'b0, 1'b0, 2'd0, 32'd5,        32'd0,        32'hFFFFFFFF, 0);
        run_op("rem 5%0",      2'd2, 1'b0, 1'b0, 2'd0, 32'd5,        32'd0,        32'd5,        0);
        run_op("div -5/0",     2'd1, 1'b1, 1'b1, 2'd0, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 0);
        run_op("rem -5%0",     2'd2, 1'b1, 1'b1, 2'd0, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 0);
        run_op("div ovf",      2'd1, 1'b1, 1'b1, 2'd0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
        run_op("rem ovf",      2'd2, 1'b1, 1'b1, 2'd0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0);

        // kill during COMPUTE drops the operation
        send(2'd0, 1'b0, 1'b0, 2'd0, 32'd1234, 32'd5678);
        repeat (10) @(negedge clk);
        check("busy in compute", {63'd0, busy}, 64'd1);
        kill = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kill = 1'b0;
        check("kill compute", {61'd0, req_ready, resp_valid, busy}, 64'b100);
        saw_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (resp_valid) saw_valid = 1'b1;
        end
        check("no resp after kill", {63'd0, saw_valid}, 64'd0);
        run_op("mul 3*3", 2'd0, 1'b0, 1'b0, 2'd0, 32'd3, 32'd3, 32'd9, 0);

        // kill in IDLE blocks acceptance
        @(negedge clk);
        kill      = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kill      = 1'b0;
        req_valid = 1'b0;
        check("kill idle", {62'd0, req_ready, busy}, 64'b10);

        // kill beats resp_ready in DONE
        send(2'd0, 1'b0, 1'b0, 2'd0, 32'd4, 32'd4);
        wait_resp(cyc);
        check("pre-kill done", {63'd0, resp_valid}, 64'd1);
        kill       = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kill       = 1'b0;
        resp_ready = 1'b0;
        check("kill done", {61'd0, req_ready, resp_valid, busy}, 64'b100);

        // reset mid-COMPUTE
        send(2'd1, 1'b0, 1'b0, 2'd0, 32'd99, 32'd3);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset mid compute", {29'd0, req_ready, resp_valid, busy, resp_result}, {29'd0, 3'b100, 32'd0});
        reset = 1'b0;
        run_op("after reset 7*6", 2'd0, 1'b0, 1'b0, 2'd0, 32'd7, 32'd6, 32'h0000002A, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
